// File: rtl/seq_muldiv_pkg.sv
// Shared constants and types for the sequential multiply/divide peripheral.
// Register offsets, op encodings and FSM state encoding.
package seq_muldiv_pkg;

    localparam logic [7:0] REG_INFO = 8'h00;
    localparam logic [7:0] REG_OPA  = 8'h04;
    localparam logic [7:0] REG_OPB  = 8'h08;
    localparam logic [7:0] REG_CTRL = 8'h0C;
    localparam logic [7:0] REG_RESH = 8'h10;
    localparam logic [7:0] REG_RESL = 8'h14;

    localparam logic [1:0] OP_MULU = 2'd0;
    localparam logic [1:0] OP_MULS = 2'd1;
    localparam logic [1:0] OP_DIVU = 2'd2;
    localparam logic [1:0] OP_DIVS = 2'd3;

    localparam int CTRL_IRQ_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_e;

    function automatic logic op_signed(logic [1:0] op);
        return !((op == OP_MULU) || (op == OP_DIVU));
    endfunction

    function automatic logic op_is_div(logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIVS);
    endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider with IDLE/RUN/FIX FSM.
// Divide datapath present only when SEQ_MULDIV_DIV_EN is defined.
module seq_muldiv_core
    import seq_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] ma_q;
    logic             neg_q;

    logic             sgn;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

`ifdef SEQ_MULDIV_DIV_EN
    logic             div_q;
    logic             negm_q;
    logic             dz_q;
    logic [WIDTH-1:0] mb_q;
    logic             dv;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_df;
`endif

    // Operand magnitudes and per-iteration arithmetic
    always_comb begin
        sgn      = op_signed(op_i);
        a_mag    = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag    = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, ma_q} : '0);
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
`ifdef SEQ_MULDIV_DIV_EN
        dv       = op_is_div(op_i);
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_df   = div_sh - {1'b0, mb_q};
`endif
    end

    // FSM and iterative datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ma_q    <= '0;
            neg_q   <= 1'b0;
`ifdef SEQ_MULDIV_DIV_EN
            div_q   <= 1'b0;
            negm_q  <= 1'b0;
            dz_q    <= 1'b0;
            mb_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        hi_q    <= '0;
                        ma_q    <= a_mag;
                        neg_q   <= sgn & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`ifdef SEQ_MULDIV_DIV_EN
                        div_q   <= dv;
                        negm_q  <= sgn & a_i[WIDTH-1];
                        dz_q    <= (b_i == '0);
                        mb_q    <= b_mag;
                        lo_q    <= dv ? a_mag : b_mag;
`else
                        lo_q    <= b_mag;
`endif
                    end
                end
                ST_RUN: begin
`ifdef SEQ_MULDIV_DIV_EN
                    if (div_q) begin
                        if (!div_df[WIDTH]) begin
                            hi_q <= div_df[WIDTH-1:0];
                            lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_q <= div_sh[WIDTH-1:0];
                            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi_q <= mul_sum[WIDTH:1];
                        lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
                    end
`else
                    hi_q <= mul_sum[WIDTH:1];
                    lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
`endif
                    if (cnt_q == LAST) begin
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sign-corrected results, valid while in FIX
    always_comb begin
        busy_o = (state_q != ST_IDLE);
        done_o = (state_q == ST_FIX);
        hi_o   = prod_fix[2*WIDTH-1:WIDTH];
        lo_o   = prod_fix[WIDTH-1:0];
`ifdef SEQ_MULDIV_DIV_EN
        if (div_q) begin
            if (dz_q) begin
                lo_o = '1;
                hi_o = negm_q ? -ma_q : ma_q;
            end else begin
                lo_o = neg_q ? -lo_q : lo_q;
                hi_o = negm_q ? -hi_q : hi_q;
            end
        end
`endif
    end

endmodule

// File: rtl/seq_muldiv.sv
// Bus-mapped sequential multiply/divide peripheral: registers, done flag, irq.
// Define SEQ_MULDIV_DIV_EN to build the divide/remainder ops.
module seq_muldiv
    import seq_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic        we,
    input  logic        re,
    output logic        irq
);

    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] resh_q;
    logic [WIDTH-1:0] resl_q;
    logic [1:0]       op_q;
    logic             irq_en_q;
    logic             done_q;

    logic             busy;
    logic             core_done;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;
    logic             wr_ok;
    logic             start;
    logic             stat_rd;
    logic [1:0]       op_wr;
    logic             unused_wd;

    assign wr_ok     = we & ~busy;
    assign start     = wr_ok & (address == REG_OPB);
    assign stat_rd   = re & (address == REG_INFO);
    assign irq       = done_q & irq_en_q;
    assign unused_wd = ^write_data;

`ifdef SEQ_MULDIV_DIV_EN
    assign op_wr = write_data[1:0];
`else
    assign op_wr = {1'b0, write_data[0]};
`endif

    seq_muldiv_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start),
        .op_i   (op_q),
        .a_i    (opa_q),
        .b_i    (write_data[WIDTH-1:0]),
        .busy_o (busy),
        .done_o (core_done),
        .hi_o   (core_hi),
        .lo_o   (core_lo)
    );

    // Operand/control capture while idle, result capture at FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q    <= '0;
            opb_q    <= '0;
            resh_q   <= '0;
            resl_q   <= '0;
            op_q     <= '0;
            irq_en_q <= 1'b0;
        end else begin
            if (wr_ok && (address == REG_OPA)) begin
                opa_q <= write_data[WIDTH-1:0];
            end
            if (start) begin
                opb_q <= write_data[WIDTH-1:0];
            end
            if (wr_ok && (address == REG_CTRL)) begin
                op_q     <= op_wr;
                irq_en_q <= write_data[CTRL_IRQ_BIT];
            end
            if (core_done) begin
                resh_q <= core_hi;
                resl_q <= core_lo;
            end
        end
    end

    // Sticky done: completion wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else if (core_done) begin
            done_q <= 1'b1;
        end else if (start || stat_rd) begin
            done_q <= 1'b0;
        end
    end

    // Combinational read mux
    always_comb begin
        read_data = '0;
        case (address)
            REG_INFO: read_data = {30'd0, done_q, busy};
            REG_OPA:  read_data = 32'(opa_q);
            REG_OPB:  read_data = 32'(opb_q);
            REG_CTRL: read_data = {27'd0, irq_en_q, 2'b00, op_q};
            REG_RESH: read_data = 32'(resh_q);
            REG_RESL: read_data = 32'(resl_q);
            default:  read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_seq_muldiv.sv
// Testbench for seq_muldiv: WIDTH=32 and WIDTH=8 instances, arithmetic model.
// Directed vectors plus per-cycle comparison against the model.
module tb_seq_muldiv;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][7:0]  addr_v;
    logic [1:0][31:0] wd_v;
    logic [1:0][31:0] rd_v;
    logic [1:0]       we_v;
    logic [1:0]       re_v;
    logic [1:0]       irq_v;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [7:0] ra [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};

    seq_muldiv #(.WIDTH(32)) u_w32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .address   (addr_v[0]),
        .write_data(wd_v[0]),
        .read_data (rd_v[0]),
        .we        (we_v[0]),
        .re        (re_v[0]),
        .irq       (irq_v[0])
    );

    seq_muldiv #(.WIDTH(8)) u_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .address   (addr_v[1]),
        .write_data(wd_v[1]),
        .read_data (rd_v[1]),
        .we        (we_v[1]),
        .re        (re_v[1]),
        .irq       (irq_v[1])
    );

    // Model state per unit
    logic [31:0] m_opa [2];
    logic [31:0] m_opb [2];
    logic [31:0] m_resh [2];
    logic [31:0] m_resl [2];
    logic [1:0]  m_op [2];
    logic        m_ien [2];
    logic        m_done [2];
    int          m_cnt [2];

    function automatic int wid(int u);
        return (u == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] dmask(int u);
        return (u == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic [63:0] model_res(int w, logic [1:0] op,
                                              logic [31:0] a, logic [31:0] b);
        logic [63:0] mask, ua, ub, p, hi, lo;
        longint sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = a[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb = b[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        hi = 64'd0;
        lo = 64'd0;
        case (op)
            2'd0: begin
                p  = ua * ub;
                hi = (p >> w) & mask;
                lo = p & mask;
            end
            2'd1: begin
                p  = 64'(sa * sb);
                hi = (p >> w) & mask;
                lo = p & mask;
            end
            2'd2: begin
                if (ub == 64'd0) begin
                    lo = mask;
                    hi = ua;
                end else begin
                    lo = ua / ub;
                    hi = ua % ub;
                end
            end
            default: begin
                if (ub == 64'd0) begin
                    lo = mask;
                    hi = ua;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = 64'(q) & mask;
                    hi = 64'(r) & mask;
                end
            end
        endcase
        return {hi[31:0], lo[31:0]};
    endfunction

    function automatic logic [31:0] exp_read(int u, logic [7:0] a);
        case (a)
            8'h00: return {30'd0, m_done[u], (m_cnt[u] > 0)};
            8'h04: return m_opa[u];
            8'h08: return m_opb[u];
            8'h0C: return {27'd0, m_ien[u], 2'b00, m_op[u]};
            8'h10: return m_resh[u];
            8'h14: return m_resl[u];
            default: return 32'd0;
        endcase
    endfunction

    // Model: register file and done flag from the documented behaviour
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) begin
                m_opa[u] = 0; m_opb[u] = 0; m_resh[u] = 0; m_resl[u] = 0;
                m_op[u] = 0; m_ien[u] = 0; m_done[u] = 0; m_cnt[u] = 0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                bit bsy, st, srd, setd;
                logic [63:0] r;
                bsy  = (m_cnt[u] > 0);
                st   = we_v[u] && (addr_v[u] == 8'h08) && !bsy;
                srd  = re_v[u] && (addr_v[u] == 8'h00);
                setd = 1'b0;
                if (we_v[u] && !bsy) begin
                    if (addr_v[u] == 8'h04) m_opa[u] = wd_v[u] & dmask(u);
                    if (addr_v[u] == 8'h08) m_opb[u] = wd_v[u] & dmask(u);
                    if (addr_v[u] == 8'h0C) begin
`ifdef SEQ_MULDIV_DIV_EN
                        m_op[u] = wd_v[u][1:0];
`else
                        m_op[u] = {1'b0, wd_v[u][0]};
`endif
                        m_ien[u] = wd_v[u][4];
                    end
                end
                if (m_cnt[u] > 0) begin
                    m_cnt[u]--;
                    if (m_cnt[u] == 0) begin
                        r = model_res(wid(u), m_op[u], m_opa[u], m_opb[u]);
                        m_resh[u] = r[63:32];
                        m_resl[u] = r[31:0];
                        setd = 1'b1;
                    end
                end
                if (st) m_cnt[u] = wid(u) + 1;
                if (setd) m_done[u] = 1'b1;
                else if (st || srd) m_done[u] = 1'b0;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of read data and irq against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                chk("model_rd", rd_v[u], exp_read(u, addr_v[u]));
                chk("model_irq", {31'd0, irq_v[u]},
                    {31'd0, m_done[u] & m_ien[u]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(int u, logic [7:0] a, logic [31:0] d);
        addr_v[u] = a;
        wd_v[u]   = d;
        we_v[u]   = 1'b1;
        tick();
        we_v[u]   = 1'b0;
        addr_v[u] = 8'h00;
        wd_v[u]   = 32'd0;
    endtask

    task automatic rdc(int u, logic [7:0] a, logic [31:0] e, string nm);
        addr_v[u] = a;
        @(negedge clk);
        chk(nm, rd_v[u], e);
        tick();
        addr_v[u] = 8'h00;
    endtask

    task automatic rds(int u, logic [31:0] e, string nm);
        addr_v[u] = 8'h00;
        re_v[u]   = 1'b1;
        @(negedge clk);
        chk(nm, rd_v[u], e);
        tick();
        re_v[u]   = 1'b0;
    endtask

    task automatic wait_done(int u, int exp_busy);
        int n;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (rd_v[u][0]) n++;
            else if (n > 0) break;
        end
        tick();
        if (exp_busy >= 0) chk("busy_cycles", 32'(n), 32'(exp_busy));
    endtask

    task automatic run(int u, logic [31:0] c, logic [31:0] a,
                       logic [31:0] b, int exp_busy);
        wr(u, 8'h0C, c);
        wr(u, 8'h04, a);
        wr(u, 8'h08, b);
        wait_done(u, exp_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        addr_v = '0; wd_v = '0; we_v = '0; re_v = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 6; k++) rdc(u, ra[k], 32'd0, "reset_reg");
            chk("reset_irq", {31'd0, irq_v[u]}, 32'd0);
        end

        run(0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        rdc(0, 8'h10, 32'hFFFF_FFFE, "mulu_hi");
        rdc(0, 8'h14, 32'h0000_0001, "mulu_lo");
        rds(0, 32'h2, "mulu_stat");
        rdc(0, 8'h00, 32'h0, "stat_clr");

        run(0, 32'h1, 32'hFFFF_FFFD, 32'h7, 33);
        rdc(0, 8'h10, 32'hFFFF_FFFF, "muls_hi");
        rdc(0, 8'h14, 32'hFFFF_FFEB, "muls_lo");

        run(0, 32'h3, 32'hFFFF_FFF9, 32'h2, 33);
`ifdef SEQ_MULDIV_DIV_EN
        rdc(0, 8'h14, 32'hFFFF_FFFD, "divs_q");
        rdc(0, 8'h10, 32'hFFFF_FFFF, "divs_r");
        rdc(0, 8'h0C, 32'h3, "ctrl_op3");
`else
        rdc(0, 8'h14, 32'hFFFF_FFF2, "op3_muls_lo");
        rdc(0, 8'h10, 32'hFFFF_FFFF, "op3_muls_hi");
        rdc(0, 8'h0C, 32'h1, "ctrl_op3");
`endif

        run(0, 32'h2, 32'h1234, 32'h0, 33);
`ifdef SEQ_MULDIV_DIV_EN
        rdc(0, 8'h14, 32'hFFFF_FFFF, "div0_q");
        rdc(0, 8'h10, 32'h0000_1234, "div0_r");
        rdc(0, 8'h0C, 32'h2, "ctrl_op2");
`else
        rdc(0, 8'h14, 32'h0, "op2_mulu_lo");
        rdc(0, 8'h10, 32'h0, "op2_mulu_hi");
        rdc(0, 8'h0C, 32'h0, "ctrl_op2");
`endif

        wr(0, 8'h0C, 32'h10);
        wr(0, 8'h04, 32'h6);
        wr(0, 8'h08, 32'h7);
        tick();
        tick();
        wr(0, 8'h04, 32'h5);
        wait_done(0, -1);
        rdc(0, 8'h04, 32'h6, "opa_protect");
        rdc(0, 8'h14, 32'h2A, "protect_lo");
        rdc(0, 8'h10, 32'h0, "protect_hi");
        chk("irq_on", {31'd0, irq_v[0]}, 32'd1);
        rds(0, 32'h2, "irq_stat");
        chk("irq_off", {31'd0, irq_v[0]}, 32'd0);

        run(1, 32'h0, 32'hFF, 32'hFF, 9);
        rdc(1, 8'h10, 32'hFE, "w8_hi");
        rdc(1, 8'h14, 32'h01, "w8_lo");

        wr(1, 8'h08, 32'hFF);
        repeat (8) tick();
        re_v[1] = 1'b1;
        tick();
        re_v[1] = 1'b0;
        rdc(1, 8'h00, 32'h2, "set_wins");

        wr(1, 8'h04, 32'h3);
        wr(1, 8'h08, 32'h5);
        repeat (8) tick();
        wr(1, 8'h08, 32'h9);
        repeat (3) tick();
        rdc(1, 8'h08, 32'h5, "fix_opb_ignored");
        rdc(1, 8'h14, 32'h0F, "fix_lo");
        rds(1, 32'h2, "fix_stat");

        run(1, 32'h1, 32'h80, 32'hFF, 9);
        rdc(1, 8'h10, 32'h00, "w8_muls_hi");
        rdc(1, 8'h14, 32'h80, "w8_muls_lo");
`ifdef SEQ_MULDIV_DIV_EN
        run(1, 32'h3, 32'h80, 32'hFF, 9);
        rdc(1, 8'h14, 32'h80, "ovf_q");
        rdc(1, 8'h10, 32'h00, "ovf_r");
        run(1, 32'h3, 32'hF9, 32'h0, 9);
        rdc(1, 8'h14, 32'hFF, "sdiv0_q");
        rdc(1, 8'h10, 32'hF9, "sdiv0_r");
`endif

        wr(0, 8'h0C, 32'h11);
        wr(0, 8'h04, 32'h9);
        wr(0, 8'h08, 32'h9);
        repeat (5) tick();
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) rdc(0, ra[k], 32'd0, "midrst_reg");
        chk("midrst_irq", {31'd0, irq_v[0]}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        rdc(0, 8'h00, 32'h0, "post_rst_stat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
